imm_encode_unit: RTL
====================

# imm_encode_unit

Pipelined immediate encoder: the inverse of the decode-stage immediate extender. It takes a 32-bit immediate, an immediate-format code and a base instruction word, and produces the instruction word with the immediate swizzled into its format-specific bit positions. It also flags any immediate the format cannot represent. It sits in the instruction loader/test-program path in front of instruction memory, behind a valid/ready stream on both sides.

## Interface
Parameters:
- ERR_CNT_W, 16, width of the saturating error counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  unit can accept a beat
- ImmFormat  in  3  000 I, 001 S, 010 B, 011 J, 100 U; 101–111 invalid
- imm  in  32  immediate value (sign-extended / U-type form)
- base_instr  in  32  instruction word; bits in the format's immediate field are ignored
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- instr  out  32  encoded instruction
- out_err  out  1  immediate not representable, or invalid format
- err_count  out  ERR_CNT_W  saturating count of accepted error beats

Clocking: one clock; reset is asynchronous and active-low (clk, rst_n).

## Operation
- Field placement (instr bit ← imm bit); all other bits come from base_instr:
  - I: 31:20 ← 11:0
  - S: 31:25 ← 11:5; 11:7 ← 4:0
  - B: 31 ← 12; 7 ← 11; 30:25 ← 10:5; 11:8 ← 4:1
  - J: 31 ← 20; 19:12 ← 19:12; 20 ← 11; 30:21 ← 10:1
  - U: 31:12 ← 31:12
- Representability; out_err=1 if violated:
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal, and imm[0]=0.
  - J: imm[31:20] all equal, and imm[0]=0.
  - U: imm[11:0]=0.
  - Formats 101–111 always set out_err.
- On error, instr = base_instr unmodified.
- Round-trip property: whenever out_err=0, decoding instr with the same format returns imm exactly.
- err_count increments on each output handshake (out_valid & out_ready) with out_err=1, and saturates at all-ones.

## Timing
- Two register stages:
  - S1 captures inputs, fit check and swizzled field.
  - S2 holds the merged instr/out_err.
- Latency: input handshake in cycle N gives out_valid in cycle N+2 when there is no backpressure.
- Throughput: one beat per cycle.
- Ready logic: in_ready = !s1_valid | (!s2_valid | out_ready). A stage advances only when the stage after it is empty or draining.
- With out_ready low, exactly two beats are buffered, then in_ready drops. No beat is dropped or duplicated.
- instr, out_err and out_valid are held stable while out_valid & !out_ready.
- Input signals are sampled only on in_valid & in_ready. Their value is don't-care otherwise.
- Reset (asynchronous, any cycle, including mid-stream):
  - s1_valid and s2_valid clear; out_valid=0, instr=0, out_err=0, err_count=0.
  - in_ready=1 from the first cycle after rst_n deasserts.
  - In-flight beats are discarded.
- An error beat accepted in the same cycle that err_count is at max leaves the counter at max.

## Structure
- Shared package imm_pkg:
  - imm_fmt_e enum (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U) on 3 bits, shared with the decode-side extender.
  - Per-format field mask constants, e.g. IMM_MASK_B = 32'hFE000F80.
- One combinational sub-module, imm_swizzle: format + imm → field bits, field mask and fit flag. It is instantiated in S1.
- The pipeline/handshake logic and the counter live in the top module.

## Test plan
- I format, base 0x00000013, imm 0x000007FF → instr 0x7FF00013, out_err=0 at cycle N+2. Same base with imm 0x00000800 → instr 0x00000013, out_err=1, err_count=1.
- B format, base 0x00000063, imm 0xFFFFFFFC → 0xFE000EE3. S format, base 0x00002023, imm 0xFFFFFFFF → 0xFE002FA3.
- J format, base 0x0000006F, imm 0x00000800 → 0x0010006F. Same with imm 0x00000801 → out_err=1 (odd offset).
- U format, base 0x00000037: imm 0x12345000 → 0x12345037; imm 0x12345001 → out_err=1. Format 101 → out_err=1.
- Backpressure: offer 4 beats back-to-back with out_ready=0.
  - Expected: 2 beats accepted, then in_ready=0; outputs stay stable.
  - Release out_ready: 4 beats delivered in order, one per cycle, none lost.
- Reset asserted with 2 beats in flight → out_valid=0 and err_count=0 immediately. After release, a new beat emerges 2 cycles after acceptance. Random round-trip check against the extender, 10k beats, out_err=0 cases exact.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared immediate-format definitions used by the encoder here and the decode-side extender.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_fmt_e;

  // Instruction bits owned by each format's immediate field
  localparam logic [31:0] IMM_MASK_I = 32'hFFF00000;
  localparam logic [31:0] IMM_MASK_S = 32'hFE000F80;
  localparam logic [31:0] IMM_MASK_B = 32'hFE000F80;
  localparam logic [31:0] IMM_MASK_J = 32'hFFFFF000;
  localparam logic [31:0] IMM_MASK_U = 32'hFFFFF000;

  // True when imm[31:msb] are all equal, i.e. imm is a sign extension of imm[msb:0]
  function automatic logic fits_signed(input logic [31:0] imm, input int msb);
    logic [31:0] hi;
    hi = $signed(imm) >>> msb;
    return (hi == 32'h0) || (hi == 32'hFFFFFFFF);
  endfunction

endpackage

// File: rtl/imm_swizzle.sv
// Combinational format-specific placement of an immediate into instruction bit positions,
// with the matching field mask and a representability flag.
module imm_swizzle
  import imm_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [31:0] imm,
  output logic [31:0] field,
  output logic [31:0] mask,
  output logic        fit
);

  always_comb begin
    field = 32'h0;
    mask  = 32'h0;
    fit   = 1'b0;
    case (fmt)
      IMM_I: begin
        field = {imm[11:0], 20'b0};
        mask  = IMM_MASK_I;
        fit   = fits_signed(imm, 11);
      end
      IMM_S: begin
        field = {imm[11:5], 13'b0, imm[4:0], 7'b0};
        mask  = IMM_MASK_S;
        fit   = fits_signed(imm, 11);
      end
      IMM_B: begin
        field = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
        mask  = IMM_MASK_B;
        fit   = fits_signed(imm, 12) && !imm[0];
      end
      IMM_J: begin
        field = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
        mask  = IMM_MASK_J;
        fit   = fits_signed(imm, 20) && !imm[0];
      end
      IMM_U: begin
        field = {imm[31:12], 12'b0};
        mask  = IMM_MASK_U;
        fit   = (imm[11:0] == 12'h0);
      end
      default: begin
        // Reserved formats never fit; base word passes through with an error
        field = 32'h0;
        mask  = 32'h0;
        fit   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/imm_encode_unit.sv
// Two-stage valid/ready immediate encoder: S1 registers swizzled field and fit flag,
// S2 registers the merged instruction; saturating counter of delivered error beats.
module imm_encode_unit
  import imm_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           ImmFormat,
  input  logic [31:0]          imm,
  input  logic [31:0]          base_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          instr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [31:0] sw_field;
  logic [31:0] sw_mask;
  logic        sw_fit;

  logic        s1_valid;
  logic [31:0] s1_base;
  logic [31:0] s1_field;
  logic [31:0] s1_mask;
  logic        s1_fit;

  logic        s2_valid;
  logic [31:0] s2_instr;
  logic        s2_err;

  logic        s2_adv;
  logic        s1_adv;
  logic        in_fire;
  logic        out_fire;
  logic [31:0] merged;

  imm_swizzle u_swizzle (
    .fmt   (ImmFormat),
    .imm   (imm),
    .field (sw_field),
    .mask  (sw_mask),
    .fit   (sw_fit)
  );

  // A stage may load when it is empty or its contents move on this cycle
  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid && out_ready;

  assign merged = s1_fit ? ((s1_base & ~s1_mask) | (s1_field & s1_mask)) : s1_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_base  <= 32'h0;
      s1_field <= 32'h0;
      s1_mask  <= 32'h0;
      s1_fit   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_fire) begin
        s1_base  <= base_instr;
        s1_field <= sw_field;
        s1_mask  <= sw_mask;
        s1_fit   <= sw_fit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_instr <= 32'h0;
      s2_err   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_instr <= merged;
        s2_err   <= !s1_fit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (out_fire && s2_err && (err_count != {ERR_CNT_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end

  assign out_valid = s2_valid;
  assign instr     = s2_instr;
  assign out_err   = s2_err;

endmodule
